// File: rtl/pcm_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// pcm_serializer_pkg
//   Shared types and elaboration-time helpers for the PCM bit serializer.
//   - state_e        : serializer state (IDLE, SHIFT)
//   - calc_div       : system-clock cycles per serial bit
//   - div_is_exact   : true when the bit rate divides the system clock exactly
//   - calc_cnt_width : divider counter width, $clog2(DIV) but at least 1 bit
// -----------------------------------------------------------------------------
package pcm_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic int calc_div(input int sys_hz, input int bit_hz);
      if (bit_hz <= 0) return 0;
      return sys_hz / bit_hz;
   endfunction

   function automatic bit div_is_exact(input int sys_hz, input int bit_hz);
      if (bit_hz <= 0) return 1'b0;
      return (sys_hz >= bit_hz) && ((sys_hz % bit_hz) == 0);
   endfunction

   function automatic int calc_cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/pcm_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// pcm_bit_serializer_if
//   Word-transfer handshake between the sample source and the serializer.
//   A word moves on a rising clock edge where data_valid_i and data_ready_o
//   are both high.
//   - data_i       : PCM word, WORD_LENGTH bits      (source -> serializer)
//   - data_valid_i : data_i is valid                 (source -> serializer)
//   - data_ready_o : serializer holding buffer empty (serializer -> source)
//   Modports: master = sample source, slave = serializer.
// -----------------------------------------------------------------------------
interface pcm_bit_serializer_if #(
   parameter int WORD_LENGTH = 16
) ();

   logic [WORD_LENGTH-1:0] data_i;
   logic                   data_valid_i;
   logic                   data_ready_o;

   modport master (
      output data_i,
      output data_valid_i,
      input  data_ready_o
   );

   modport slave (
      input  data_i,
      input  data_valid_i,
      output data_ready_o
   );

endinterface

// File: rtl/pcm_bit_serializer_rate_tick_gen.sv
// -----------------------------------------------------------------------------
// rate_tick_gen
//   Free-running divider producing one tick every DIV enabled clock cycles.
//   The count runs 0..DIV-1; tick_o is high in the cycle the count equals
//   DIV-1. With DIV=1 every enabled cycle is a tick. While enable_i is low the
//   count is held at 0, so the first tick after enabling comes DIV cycles later.
//   Ports:
//   - clock_i  : system clock, rising edge
//   - reset_i  : asynchronous, active-high reset
//   - enable_i : run enable
//   - tick_o   : one-cycle tick (combinational from the count register)
// -----------------------------------------------------------------------------
module rate_tick_gen
   import pcm_serializer_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic enable_i,
   output logic tick_o
);

   localparam int               CNT_W    = calc_cnt_width(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   if (DIV < 1) begin : g_bad_div
      $error("rate_tick_gen: DIV must be >= 1");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: next-state logic uses blocking '=' in always_comb; the register
   // block below uses non-blocking '<=' only, so every flop samples the same
   // pre-edge values.
   always_comb begin
      tick_o = enable_i && (cnt_q == CNT_LAST);
      cnt_d  = cnt_q;
      if (!enable_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pcm_bit_serializer.sv
// -----------------------------------------------------------------------------
// pcm_bit_serializer
//   Gapless PCM word serializer. Words arrive over a valid/ready handshake into
//   a one-word holding buffer and are shifted out one bit per bit period on
//   pwm_audio_o. The bit period is DIV = SYSTEM_FREQUENCY/BIT_FREQUENCY system
//   clocks. When a word ends and the buffer is full, the next word is loaded on
//   the same tick, so back-to-back words have no idle bit between them.
//   Ports:
//   - clock_i      : system clock, rising edge
//   - reset_i      : asynchronous, active-high reset
//   - enable_i     : run enable; low aborts shifting and holds the divider
//   - src_if       : slave side of the word handshake (data/valid/ready)
//   - pwm_audio_o  : serial bit output (registered), IDLE_LEVEL when idle
//   - word_start_o : pulse in the cycle a word's first bit is driven
//   - done_o       : pulse when a word's last bit period ends
//   - underrun_o   : pulse when a word ends while enabled and buffer is empty
//   - busy_o       : high while in SHIFT
// -----------------------------------------------------------------------------
module pcm_bit_serializer
   import pcm_serializer_pkg::*;
#(
   parameter int WORD_LENGTH      = 16,
   parameter int SYSTEM_FREQUENCY = 100000000,
   parameter int BIT_FREQUENCY    = 1000000,
   parameter bit MSB_FIRST        = 1'b1,
   parameter bit IDLE_LEVEL       = 1'b0
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                enable_i,
   pcm_bit_serializer_if.slave src_if,
   output logic                pwm_audio_o,
   output logic                word_start_o,
   output logic                done_o,
   output logic                underrun_o,
   output logic                busy_o
);

   localparam int                   DIV          = calc_div(SYSTEM_FREQUENCY, BIT_FREQUENCY);
   localparam int                   BIT_CNT_W    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(WORD_LENGTH - 1);

   if (WORD_LENGTH < 2) begin : g_bad_word_length
      $error("pcm_bit_serializer: WORD_LENGTH must be >= 2");
   end

   if (!div_is_exact(SYSTEM_FREQUENCY, BIT_FREQUENCY)) begin : g_bad_div
      $error("pcm_bit_serializer: SYSTEM_FREQUENCY/BIT_FREQUENCY must be an integer >= 1");
   end

   // Bit that goes on the line first for a freshly loaded word.
   function automatic logic first_bit(input logic [WORD_LENGTH-1:0] w);
      return MSB_FIRST ? w[WORD_LENGTH-1] : w[0];
   endfunction

   // Shift the word so the next bit to send sits where first_bit() reads it.
   function automatic logic [WORD_LENGTH-1:0] next_shift(input logic [WORD_LENGTH-1:0] w);
      return MSB_FIRST ? {w[WORD_LENGTH-2:0], 1'b0} : {1'b0, w[WORD_LENGTH-1:1]};
   endfunction

   logic tick;

   rate_tick_gen #(
      .DIV (DIV)
   ) u_rate_tick_gen (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .enable_i (enable_i),
      .tick_o   (tick)
   );

   state_e                 state_q,      state_d;
   logic [WORD_LENGTH-1:0] shift_q,      shift_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
   logic [WORD_LENGTH-1:0] hold_q,       hold_d;
   logic                   hold_valid_q, hold_valid_d;
   logic                   ready_q,      ready_d;
   logic                   pwm_q,        pwm_d;
   logic                   word_start_q, word_start_d;
   logic                   done_q,       done_d;
   logic                   underrun_q,   underrun_d;
   logic                   busy_q,       busy_d;

   logic                   accept;
   logic                   load;
   logic [WORD_LENGTH-1:0] shift_next;

   // NOTE: every signal driven here gets a default at the top of the block, so
   // no branch leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      pwm_d        = pwm_q;
      word_start_d = 1'b0;
      done_d       = 1'b0;
      underrun_d   = 1'b0;
      load         = 1'b0;
      shift_next   = next_shift(shift_q);

      // Accept only into an empty buffer, so accept and load never coincide.
      accept = src_if.data_valid_i && !hold_valid_q;

      case (state_q)
         IDLE: begin
            // A tick without a buffered word is simply ignored.
            if (tick && hold_valid_q) begin
               load = 1'b1;
            end
         end
         SHIFT: begin
            if (!enable_i) begin
               // Abort: the partial word is dropped, the buffer is kept.
               state_d = IDLE;
               pwm_d   = IDLE_LEVEL;
            end else if (tick) begin
               if (bit_cnt_q != '0) begin
                  shift_d   = shift_next;
                  pwm_d     = first_bit(shift_next);
                  bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
               end else begin
                  done_d = 1'b1;
                  if (hold_valid_q) begin
                     load = 1'b1;
                  end else begin
                     underrun_d = 1'b1;
                     pwm_d      = IDLE_LEVEL;
                     state_d    = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            pwm_d   = IDLE_LEVEL;
         end
      endcase

      if (load) begin
         shift_d      = hold_q;
         pwm_d        = first_bit(hold_q);
         bit_cnt_d    = BIT_CNT_LAST;
         word_start_d = 1'b1;
         hold_valid_d = 1'b0;
         state_d      = SHIFT;
      end

      if (accept) begin
         hold_d       = src_if.data_i;
         hold_valid_d = 1'b1;
      end

      busy_d  = (state_d == SHIFT);
      ready_d = !hold_valid_d;
   end

   // NOTE: the word registers (hold_q, shift_q) are reset along with the
   // control state; a reset mid-word must discard the buffered word, and
   // clearing the data keeps the line and the buffer free of stale values.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         pwm_q        <= IDLE_LEVEL;
         word_start_q <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         ready_q      <= ready_d;
         pwm_q        <= pwm_d;
         word_start_q <= word_start_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
         busy_q       <= busy_d;
      end
   end

   assign src_if.data_ready_o = ready_q;
   assign pwm_audio_o         = pwm_q;
   assign word_start_o        = word_start_q;
   assign done_o              = done_q;
   assign underrun_o          = underrun_q;
   assign busy_o              = busy_q;

endmodule

// File: tb/tb_pcm_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_pcm_bit_serializer
//   Directed bench for pcm_bit_serializer with three instances:
//   - dut_a : WORD_LENGTH=4,  DIV=3, MSB first, idle level 0
//   - dut_b : WORD_LENGTH=4,  DIV=3, LSB first, idle level 1
//   - dut_c : WORD_LENGTH=16, DIV=1, MSB first, idle level 0
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pcm_bit_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instances a (index 0) and b (index 1)
   logic [1:0] en_ab;
   logic [1:0] valid_ab;
   logic [3:0] data_ab [2];
   wire  [1:0] ready_ab, pwm_ab, ws_ab, done_ab, ur_ab, busy_ab;

   // Instance c
   logic        en_c;
   logic        valid_c;
   logic [15:0] data_c;
   wire         ready_c, pwm_c, ws_c, done_c, ur_c, busy_c;

   logic [15:0] words_c [10] = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000,
                                 16'h1234, 16'hFEDC, 16'h5555, 16'hAAAA, 16'h0F0F};

   pcm_bit_serializer_if #(.WORD_LENGTH(4))  if_a ();
   pcm_bit_serializer_if #(.WORD_LENGTH(4))  if_b ();
   pcm_bit_serializer_if #(.WORD_LENGTH(16)) if_c ();

   assign if_a.data_i       = data_ab[0];
   assign if_a.data_valid_i = valid_ab[0];
   assign ready_ab[0]       = if_a.data_ready_o;
   assign if_b.data_i       = data_ab[1];
   assign if_b.data_valid_i = valid_ab[1];
   assign ready_ab[1]       = if_b.data_ready_o;
   assign if_c.data_i       = data_c;
   assign if_c.data_valid_i = valid_c;
   assign ready_c           = if_c.data_ready_o;

   pcm_bit_serializer #(
      .WORD_LENGTH(4), .SYSTEM_FREQUENCY(3000000), .BIT_FREQUENCY(1000000),
      .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
   ) dut_a (
      .clock_i(clk), .reset_i(rst), .enable_i(en_ab[0]), .src_if(if_a),
      .pwm_audio_o(pwm_ab[0]), .word_start_o(ws_ab[0]), .done_o(done_ab[0]),
      .underrun_o(ur_ab[0]), .busy_o(busy_ab[0])
   );

   pcm_bit_serializer #(
      .WORD_LENGTH(4), .SYSTEM_FREQUENCY(3000000), .BIT_FREQUENCY(1000000),
      .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
   ) dut_b (
      .clock_i(clk), .reset_i(rst), .enable_i(en_ab[1]), .src_if(if_b),
      .pwm_audio_o(pwm_ab[1]), .word_start_o(ws_ab[1]), .done_o(done_ab[1]),
      .underrun_o(ur_ab[1]), .busy_o(busy_ab[1])
   );

   pcm_bit_serializer #(
      .WORD_LENGTH(16), .SYSTEM_FREQUENCY(1000000), .BIT_FREQUENCY(1000000),
      .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
   ) dut_c (
      .clock_i(clk), .reset_i(rst), .enable_i(en_c), .src_if(if_c),
      .pwm_audio_o(pwm_c), .word_start_o(ws_c), .done_o(done_c),
      .underrun_o(ur_c), .busy_o(busy_c)
   );

   // Offer one word on instance u; it is accepted on the next rising edge.
   task automatic send_word(input int u, input logic [3:0] w);
      data_ab[u]  = w;
      valid_ab[u] = 1'b1;
      checks++;
      if (ready_ab[u] !== 1'b1) begin
         errors++;
         $display("FAIL send_ready u%0d: data_ready_o=%b expected 1", u, ready_ab[u]);
      end
      @(negedge clk);
      valid_ab[u] = 1'b0;
   endtask

   // Advance until word_start_o is seen, at most 'bound' cycles.
   task automatic wait_start(input int u, input int bound, output int lat);
      lat = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         lat++;
         if (ws_ab[u] === 1'b1) break;
      end
      checks++;
      if (ws_ab[u] !== 1'b1) begin
         errors++;
         $display("FAIL start_timeout u%0d: word_start_o=%b after %0d cycles, expected 1", u, ws_ab[u], lat);
      end
   endtask

   // From the word_start_o sample: 4 bits x 3 cycles, then done+underrun.
   // seq holds the expected line bits, first-sent bit in seq[3].
   task automatic check_word(input int u, input logic [3:0] seq, input logic idle_lvl, input string tag);
      logic [4:0] got;
      logic [4:0] exp;
      for (int s = 0; s < 14; s++) begin
         got = {pwm_ab[u], ws_ab[u], done_ab[u], ur_ab[u], busy_ab[u]};
         if (s < 12)       exp = {seq[3 - s/3], (s == 0), 1'b0, 1'b0, 1'b1};
         else if (s == 12) exp = {idle_lvl, 1'b0, 1'b1, 1'b1, 1'b0};
         else              exp = {idle_lvl, 4'b0000};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s s%0d: pwm/ws/done/ur/busy=%b expected %b", tag, s, got, exp);
         end
         if (s < 13) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [5:0] got;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      got = {pwm_ab[0], ws_ab[0], done_ab[0], ur_ab[0], busy_ab[0], ready_ab[0]};
      checks++;
      if (got !== 6'b000001) begin
         errors++;
         $display("FAIL reset_hold_a: pwm/ws/done/ur/busy/ready=%b expected 000001", got);
      end
      rst = 1'b0;
      @(negedge clk);
      got = {pwm_ab[0], ws_ab[0], done_ab[0], ur_ab[0], busy_ab[0], ready_ab[0]};
      checks++;
      if (got !== 6'b000001) begin
         errors++;
         $display("FAIL reset_a: pwm/ws/done/ur/busy/ready=%b expected 000001", got);
      end
      got = {pwm_ab[1], ws_ab[1], done_ab[1], ur_ab[1], busy_ab[1], ready_ab[1]};
      checks++;
      if (got !== 6'b100001) begin
         errors++;
         $display("FAIL reset_b: pwm/ws/done/ur/busy/ready=%b expected 100001", got);
      end
      got = {pwm_c, ws_c, done_c, ur_c, busy_c, ready_c};
      checks++;
      if (got !== 6'b000001) begin
         errors++;
         $display("FAIL reset_c: pwm/ws/done/ur/busy/ready=%b expected 000001", got);
      end
   endtask

   task automatic test_single(input int u, input logic [3:0] w, input logic [3:0] seq,
                              input logic idle_lvl, input string tag);
      int lat;
      send_word(u, w);
      wait_start(u, 6, lat);
      checks++;
      if (lat < 1 || lat > 3) begin
         errors++;
         $display("FAIL %s_latency: %0d cycles, expected 1..3", tag, lat);
      end
      check_word(u, seq, idle_lvl, tag);
   endtask

   task automatic test_back_to_back;
      int         lat;
      logic [7:0] seq8;
      logic [4:0] got;
      logic [4:0] exp;
      seq8 = 8'b1010_0101;
      send_word(0, 4'hA);
      wait_start(0, 6, lat);
      for (int s = 0; s < 26; s++) begin
         got = {pwm_ab[0], ws_ab[0], done_ab[0], ur_ab[0], busy_ab[0]};
         if (s < 24)       exp = {seq8[7 - s/3], (s == 0) || (s == 12), (s == 12), 1'b0, 1'b1};
         else if (s == 24) exp = 5'b00110;
         else              exp = 5'b00000;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL stream s%0d: pwm/ws/done/ur/busy=%b expected %b", s, got, exp);
         end
         if (s == 1 || s == 12) begin
            checks++;
            if (ready_ab[0] !== (s == 12)) begin
               errors++;
               $display("FAIL stream_ready s%0d: data_ready_o=%b expected %b", s, ready_ab[0], (s == 12));
            end
         end
         if (s == 0) begin
            data_ab[0]  = 4'h5;
            valid_ab[0] = 1'b1;
         end else begin
            valid_ab[0] = 1'b0;
         end
         if (s < 25) @(negedge clk);
      end
   endtask

   task automatic test_enable_drop;
      int         lat;
      logic [1:0] got2;
      logic [5:0] got;
      send_word(0, 4'hF);
      wait_start(0, 6, lat);
      for (int s = 0; s < 6; s++) begin
         got2 = {pwm_ab[0], busy_ab[0]};
         checks++;
         if (got2 !== 2'b11) begin
            errors++;
            $display("FAIL en_drop_bits s%0d: pwm/busy=%b expected 11", s, got2);
         end
         if (s == 0) begin
            data_ab[0]  = 4'h6;
            valid_ab[0] = 1'b1;
         end else begin
            valid_ab[0] = 1'b0;
         end
         if (s == 5) en_ab[0] = 1'b0;
         @(negedge clk);
      end
      // Disabled: idle line, no done/underrun, buffered word still held.
      for (int k = 0; k < 6; k++) begin
         got = {pwm_ab[0], ws_ab[0], done_ab[0], ur_ab[0], busy_ab[0], ready_ab[0]};
         checks++;
         if (got !== 6'b000000) begin
            errors++;
            $display("FAIL en_drop_idle k%0d: pwm/ws/done/ur/busy/ready=%b expected 000000", k, got);
         end
         if (k < 5) @(negedge clk);
      end
      en_ab[0] = 1'b1;
      wait_start(0, 6, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL en_resume_latency: %0d cycles, expected 3", lat);
      end
      check_word(0, 4'b0110, 1'b0, "en_resume_word");
   endtask

   task automatic test_reset_mid_word;
      int         lat;
      int         starts;
      logic [2:0] pre;
      logic [5:0] got;
      send_word(0, 4'hF);
      wait_start(0, 6, lat);
      data_ab[0]  = 4'h3;
      valid_ab[0] = 1'b1;
      @(negedge clk);
      valid_ab[0] = 1'b0;
      repeat (2) @(negedge clk);
      pre = {pwm_ab[0], busy_ab[0], ready_ab[0]};
      checks++;
      if (pre !== 3'b110) begin
         errors++;
         $display("FAIL reset_mid_pre: pwm/busy/ready=%b expected 110", pre);
      end
      #2 rst = 1'b1;
      #1;
      got = {pwm_ab[0], ws_ab[0], done_ab[0], ur_ab[0], busy_ab[0], ready_ab[0]};
      checks++;
      if (got !== 6'b000001) begin
         errors++;
         $display("FAIL reset_mid_async: pwm/ws/done/ur/busy/ready=%b expected 000001", got);
      end
      #1 rst = 1'b0;
      starts = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ws_ab[0] === 1'b1 || pwm_ab[0] !== 1'b0) starts++;
      end
      checks++;
      if (starts != 0) begin
         errors++;
         $display("FAIL reset_mid_buffer_lost: %0d active cycles after reset, expected 0", starts);
      end
   endtask

   task automatic test_div1_stream;
      int         idx;
      int         s;
      logic [5:0] got;
      logic [5:0] exp;
      idx = 0;
      s   = -1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (s < 0 && ws_c === 1'b1) s = 0;
         if (s >= 0 && s <= 160) begin
            got = {pwm_c, ws_c, done_c, ur_c, busy_c, ready_c};
            if (s < 160)
               exp = {words_c[s/16][15 - s%16], (s % 16 == 0), (s % 16 == 0) && (s > 0),
                      1'b0, 1'b1, (s >= 144) || (s % 16 == 0)};
            else
               exp = 6'b001101;
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL div1 s%0d: pwm/ws/done/ur/busy/ready=%b expected %b", s, got, exp);
            end
         end
         if (s >= 0) s++;
         valid_c = (idx < 10);
         if (idx < 10) data_c = words_c[idx];
         if (valid_c && ready_c === 1'b1) idx++;
         @(negedge clk);
      end
      valid_c = 1'b0;
      checks++;
      if (s <= 160 || idx != 10) begin
         errors++;
         $display("FAIL div1_complete: samples=%0d words=%0d expected >160 and 10", s, idx);
      end
   endtask

   initial begin
      rst         = 1'b1;
      en_ab       = 2'b11;
      valid_ab    = 2'b00;
      data_ab[0]  = 4'h0;
      data_ab[1]  = 4'h0;
      en_c        = 1'b1;
      valid_c     = 1'b0;
      data_c      = 16'h0000;
      test_reset();
      test_single(0, 4'b1011, 4'b1011, 1'b0, "single_msb");
      test_single(1, 4'b1011, 4'b1101, 1'b1, "single_lsb");
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_word();
      test_div1_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
